// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } ctrl_state_t;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_INIT_CYCLES = 3;
  localparam int DEF_CNT_W       = 32;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
  function automatic logic src_matches(input logic use_src,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd);
    return use_src && (rs == rd) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs and pipeline control strobes between the pipeline and the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             bus_err;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_en,
           memwb_bubble, bus_err, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, mem_req, mem_ack,
    output pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_en,
           memwb_bubble, bus_err, ctrl_state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the register a load in EX writes.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);

  assign hazard = ex_memread &&
                  (src_matches(id_use_rs1, id_rs1, ex_rd) ||
                   src_matches(id_use_rs2, id_rs2, ex_rd));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: reset drain, memory freeze/timeout, branch flush and load-use stall.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);

  ctrl_state_t       state, next_state;
  logic [INIT_W-1:0] init_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              bus_err_q;
  logic              hazard;
  logic              tmo_clr, tmo_inc, set_err;
  logic              do_init, do_freeze, do_run;
  logic              pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic              exmem_en, memwb_bubble;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  load_use_detect u_detect (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_rd      (bus.ex_rd),
    .ex_memread (bus.ex_memread),
    .hazard     (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= INIT_LOAD;
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == INIT && init_cnt != '0)
        init_cnt <= init_cnt - 1'b1;
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (tmo_inc)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (set_err)
        bus_err_q <= 1'b1;
    end
  end

  // The ack cycle of MEM_WAIT falls through to the normal RUN decode minus the memory check.
  always_comb begin
    next_state   = state;
    tmo_clr      = 1'b0;
    tmo_inc      = 1'b0;
    set_err      = 1'b0;
    do_init      = 1'b0;
    do_freeze    = 1'b0;
    do_run       = 1'b0;
    pc_en        = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_bubble = 1'b0;

    case (state)
      INIT: begin
        do_init = 1'b1;
        if (init_cnt == '0)
          next_state = RUN;
      end
      RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          do_freeze  = 1'b1;
          tmo_clr    = 1'b1;
          next_state = MEM_WAIT;
        end else begin
          do_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ack) begin
          do_freeze = 1'b1;
          tmo_inc   = 1'b1;
          if (tmo_cnt == TMO_LAST) begin
            next_state = HALT;
            set_err    = 1'b1;
          end
        end else begin
          do_run     = 1'b1;
          next_state = RUN;
        end
      end
      HALT:    do_freeze = 1'b1;
      default: next_state = INIT;
    endcase

    if (do_init) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b1;
    end

    if (do_freeze) begin
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      memwb_bubble = 1'b1;
    end

    if (do_run) begin
      exmem_en = 1'b1;
      if (bus.ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (hazard) begin
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end

    ifid_stall = ifid_stall & ~ifid_flush;
    idex_stall = idex_stall & ~idex_flush;
  end

`ifdef HAZ_PERF_CNT_EN
  logic count_window;
  assign count_window = (state == RUN) || (state == MEM_WAIT);

  // Counters saturate rather than wrap so a long run never reads back as a small number.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (count_window && !pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (count_window && ifid_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign bus.pc_en        = pc_en;
  assign bus.ifid_stall   = ifid_stall;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_stall   = idex_stall;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.bus_err      = bus_err_q;
  assign bus.ctrl_state   = state;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the five-stage pipeline register chain (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards and taken branches and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It also drains the pipeline after reset. It drives stall, flush and enable strobes into the pipeline registers and the PC, and it has no datapath of its own.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycles without `mem_ack` before entering HALT.
- INIT_CYCLES, 3: drain cycles after reset.
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the instruction in ID actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  a branch was resolved taken in EX.
- mem_req  in  1  the instruction in MEM accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_stall, ifid_flush  out  1  IF/ID hold and clear.
- idex_stall, idex_flush  out  1  ID/EX hold and clear.
- exmem_en  out  1  EX/MEM load enable.
- memwb_bubble  out  1  load a NOP (regwrite=0) into MEM/WB.
- bus_err  out  1  sticky flag for a memory timeout.
- ctrl_state  out  2  current FSM state.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
The FSM has four states: INIT=0, RUN=1, MEM_WAIT=2, HALT=3.

- **INIT**
  - Outputs: pc_en=0, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_bubble=1.
  - A down-counter loaded with INIT_CYCLES-1 on reset moves the FSM to RUN when it reaches 0.
- **RUN**: the requests below are evaluated in priority order.
  1. Memory not ready: mem_req=1 and mem_ack=0.
     - Outputs: pc_en=0, ifid_stall=1, idex_stall=1, exmem_en=0, memwb_bubble=1.
     - Next state MEM_WAIT; the timeout counter is cleared.
  2. Taken branch: ex_branch_taken=1.
     - Outputs: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1.
  3. Load-use hazard: ex_memread=1 and ex_rd≠0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)).
     - Outputs: pc_en=0, ifid_stall=1, idex_flush=1, exmem_en=1.
  4. Otherwise: pc_en=1, exmem_en=1, and all other strobes 0.
- **MEM_WAIT, mem_ack=0**
  - Outputs are identical to case 1 above.
  - The timeout counter increments.
  - When the counter reaches MEM_TIMEOUT-1, the next state is HALT and bus_err is set.
- **MEM_WAIT, mem_ack=1** (completion cycle)
  - Outputs follow the RUN decode with case 1 skipped, so a branch or load-use hazard in the same cycle is honoured.
  - Next state RUN.
- **HALT**
  - Outputs: pc_en=0, ifid_stall=1, idex_stall=1, exmem_en=0, memwb_bubble=1.
  - Left only through rst.
- Rules that hold in every state:
  - Stall and flush are never both 1 on the same register; flush wins.
  - ex_rd=0 never triggers a hazard.
  - bus_err clears only on rst.

## Timing
- All outputs are decoded combinationally from state plus the current inputs; the inputs have a same-cycle effect.
- State, the counters and bus_err update on posedge clk.
- Reset values, with rst sampled high:
  - ctrl_state=INIT, init counter=INIT_CYCLES-1, timeout counter=0, bus_err=0, stall_cnt=0, flush_cnt=0.
  - Outputs take the INIT values the cycle after the rst edge.
- A load-use hazard costs exactly 1 bubble. A taken branch flushes exactly 2 instructions.
- A memory access acked N cycles after request freezes the pipeline for N cycles.
- Reset mid-MEM_WAIT returns to INIT at the next edge, discarding the timeout count.
- Both counters saturate at 2^CNT_W-1; they do not wrap.

## Configuration
- The macro is `HAZ_PERF_CNT_EN`.
- Defined:
  - stall_cnt increments every cycle that pc_en=0 in RUN or MEM_WAIT.
  - flush_cnt increments every cycle that ifid_flush=1 in RUN or MEM_WAIT.
- Undefined: counter logic is omitted and stall_cnt and flush_cnt are tied to 0. The ports remain present.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (INIT, RUN, MEM_WAIT, HALT, 2 bits);
  - the default parameter constants;
  - the `REG_X0` constant (5'd0).
- Sub-module `load_use_detect` is the purely combinational comparator that produces the hazard bit. The top module holds the FSM, the counters and the output decode.

## Test plan
- **Reset drain:** assert rst for 1 cycle with INIT_CYCLES=3 -> pc_en=0 and ifid_flush=1 for 3 cycles, then ctrl_state=1 and pc_en=1.
- **Load-use:** ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> for exactly 1 cycle pc_en=0, ifid_stall=1, idex_flush=1. Repeat with ex_rd=0 -> no stall.
- **Branch vs. load-use:** ex_branch_taken=1 in the same cycle as the hazard -> pc_en=1, ifid_flush=1, idex_flush=1, ifid_stall=0; flush_cnt increments by 1.
- **Memory wait:** mem_req=1 with mem_ack held low 4 cycles, then high -> 4 frozen cycles (exmem_en=0, memwb_bubble=1), the ack cycle advances, ctrl_state=RUN next; stall_cnt=4.
- **Timeout:** MEM_TIMEOUT=8 and mem_ack never asserted -> after 8 MEM_WAIT cycles ctrl_state=3 and bus_err=1, persisting until rst; rst then returns to INIT with bus_err=0.
- **Reset mid-wait:** rst asserted during MEM_WAIT cycle 2 -> ctrl_state=INIT next cycle, counters 0.
